inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_if.sv | 35 +++
 rtl/inst_fetch.sv | 135 +++++++++++++
 tb/tb_inst_fetch.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - handshake bundle between the PC stage, instruction memory, decode and inst_fetch
// Signal suffixes are relative to inst_fetch: _i is driven into the fetch block, _o is driven by it.
//   PC stage : pc_i, pc_valid_i, pc_ready_o
//   memory   : imem_req_o, imem_addr_o, imem_gnt_i, imem_rvalid_i, imem_rdata_i
//   decode   : inst_valid_o, inst_o, inst_addr_o, inst_ready_i
//   control  : flush_i
// modport slave is taken by inst_fetch, modport master by whatever surrounds it.
interface inst_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] pc_i;
    logic              pc_valid_i;
    logic              pc_ready_o;
    logic              imem_req_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic              imem_gnt_i;
    logic              imem_rvalid_i;
    logic [DATA_W-1:0] imem_rdata_i;
    logic              inst_valid_o;
    logic [DATA_W-1:0] inst_o;
    logic [ADDR_W-1:0] inst_addr_o;
    logic              inst_ready_i;
    logic              flush_i;

    modport slave (
        input  pc_i, pc_valid_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, inst_ready_i, flush_i,
        output pc_ready_o, imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_addr_o
    );

    modport master (
        output pc_i, pc_valid_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, inst_ready_i, flush_i,
        input  pc_ready_o, imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_addr_o
    );
endinterface

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - single-outstanding instruction fetch with a small output buffer
// Ports:
//   clk_i  : clock, all state updates on the rising edge
//   rst_i  : synchronous active-high reset, overrides flush and all handshakes
//   bus    : inst_fetch_if.slave carrying the PC, memory and decode handshakes plus flush_i
module inst_fetch #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BUF_DEPTH = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    inst_fetch_if.slave   bus
);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic [DATA_W-1:0] data_q  [BUF_DEPTH];
    logic [ADDR_W-1:0] iaddr_q [BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic pc_ready;
    logic accept;
    logic push;
    logic pop;

    // Accepting only with a free slot reserves room for the single in-flight
    // response, so a push can never land on a full buffer.
    assign pc_ready = (state_q == IDLE) && (count_q < CNT_W'(BUF_DEPTH)) && !bus.flush_i;
    assign accept   = bus.pc_valid_i && pc_ready;
    assign push     = (state_q == WAIT) && bus.imem_rvalid_i && !bus.flush_i;
    assign pop      = (count_q != '0) && bus.inst_ready_i;

    assign bus.pc_ready_o   = pc_ready;
    assign bus.imem_req_o   = (state_q == REQ);
    assign bus.imem_addr_o  = addr_q;
    assign bus.inst_valid_o = (count_q != '0);
    assign bus.inst_o       = data_q[rd_ptr_q];
    assign bus.inst_addr_o  = iaddr_q[rd_ptr_q];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = REQ;
                    addr_d  = {bus.pc_i[ADDR_W-1:2], 2'b00};
                end
            end
            REQ: begin
                // A granted request is already in memory's hands, so its
                // response must still be absorbed in DROP.
                if (bus.flush_i) begin
                    state_d = bus.imem_gnt_i ? DROP : IDLE;
                end else if (bus.imem_gnt_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.imem_rvalid_i) begin
                    state_d = IDLE;
                end else if (bus.flush_i) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (bus.imem_rvalid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PTR_W'(BUF_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PTR_W'(BUF_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            // Cleared so the head outputs read zero after reset.
            for (int i = 0; i < BUF_DEPTH; i++) begin
                data_q[i]  <= '0;
                iaddr_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                data_q[wr_ptr_q]  <= bus.imem_rdata_i;
                iaddr_q[wr_ptr_q] <= addr_q;
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch: directed scenarios plus randomized scoreboard run
module tb_inst_fetch;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    inst_fetch_if #(.ADDR_W(32), .DATA_W(32)) ifc ();

    inst_fetch #(.ADDR_W(32), .DATA_W(32), .BUF_DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifc)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifc.pc_i = '0; ifc.pc_valid_i = 0; ifc.imem_gnt_i = 0; ifc.imem_rvalid_i = 0;
        ifc.imem_rdata_i = '0; ifc.inst_ready_i = 0; ifc.flush_i = 0;
    endtask

    // Stimulus only: accept a, grant after gnt_wait stall cycles, respond with d next cycle.
    task automatic do_fetch(input logic [31:0] a, input logic [31:0] d, input int gnt_wait, output bit ok);
        ok = 0;
        ifc.pc_i = a; ifc.pc_valid_i = 1;
        for (int t = 0; t < 20 && !ok; t++) begin
            #1;
            if (ifc.pc_ready_o) ok = 1;
            @(posedge clk); #1;
        end
        ifc.pc_valid_i = 0;
        if (ok) begin
            repeat (gnt_wait) cyc();
            ifc.imem_gnt_i = 1; cyc(); ifc.imem_gnt_i = 0;
            ifc.imem_rvalid_i = 1; ifc.imem_rdata_i = d; cyc(); ifc.imem_rvalid_i = 0;
        end
    endtask

    task automatic test_reset();
        ifc.pc_i = 32'h1234; ifc.pc_valid_i = 1; ifc.flush_i = 1; ifc.imem_gnt_i = 1;
        ifc.imem_rvalid_i = 1; ifc.imem_rdata_i = 32'hFFFF_FFFF; ifc.inst_ready_i = 1;
        rst = 1;
        repeat (2) cyc();
        n_cmp++; if (ifc.imem_req_o !== 1'b0) begin n_bad++; $display("FAIL rst_imem_req: got %b want 0", ifc.imem_req_o); end
        n_cmp++; if (ifc.imem_addr_o !== 32'h0) begin n_bad++; $display("FAIL rst_imem_addr: got %h want 0", ifc.imem_addr_o); end
        n_cmp++; if (ifc.inst_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_inst_valid: got %b want 0", ifc.inst_valid_o); end
        n_cmp++; if (ifc.inst_o !== 32'h0) begin n_bad++; $display("FAIL rst_inst: got %h want 0", ifc.inst_o); end
        n_cmp++; if (ifc.inst_addr_o !== 32'h0) begin n_bad++; $display("FAIL rst_inst_addr: got %h want 0", ifc.inst_addr_o); end
        idle_inputs();
        rst = 0;
        repeat (2) cyc();
        n_cmp++; if (ifc.imem_req_o !== 1'b0) begin n_bad++; $display("FAIL post_rst_imem_req: got %b want 0", ifc.imem_req_o); end
        n_cmp++; if (ifc.inst_valid_o !== 1'b0) begin n_bad++; $display("FAIL post_rst_inst_valid: got %b want 0", ifc.inst_valid_o); end
        n_cmp++; if (ifc.pc_ready_o !== 1'b1) begin n_bad++; $display("FAIL post_rst_pc_ready: got %b want 1", ifc.pc_ready_o); end
    endtask

    task automatic test_basic();
        // cycle 0: accept
        ifc.pc_i = 32'h0; ifc.pc_valid_i = 1; #1;
        n_cmp++; if (ifc.pc_ready_o !== 1'b1) begin n_bad++; $display("FAIL basic_pc_ready: got %b want 1", ifc.pc_ready_o); end
        cyc(); ifc.pc_valid_i = 0;
        // cycle 1: request visible, granted
        n_cmp++; if (ifc.imem_req_o !== 1'b1) begin n_bad++; $display("FAIL basic_req: got %b want 1", ifc.imem_req_o); end
        n_cmp++; if (ifc.imem_addr_o !== 32'h0) begin n_bad++; $display("FAIL basic_addr: got %h want 0", ifc.imem_addr_o); end
        ifc.imem_gnt_i = 1; cyc(); ifc.imem_gnt_i = 0;
        // cycle 2: response
        n_cmp++; if (ifc.inst_valid_o !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid: got %b want 0", ifc.inst_valid_o); end
        ifc.imem_rvalid_i = 1; ifc.imem_rdata_i = 32'h0000_0013; cyc(); ifc.imem_rvalid_i = 0;
        // cycle 3: instruction available
        n_cmp++; if (ifc.inst_valid_o !== 1'b1) begin n_bad++; $display("FAIL basic_valid_c3: got %b want 1", ifc.inst_valid_o); end
        n_cmp++; if (ifc.inst_o !== 32'h0000_0013) begin n_bad++; $display("FAIL basic_inst: got %h want 00000013", ifc.inst_o); end
        n_cmp++; if (ifc.inst_addr_o !== 32'h0) begin n_bad++; $display("FAIL basic_inst_addr: got %h want 0", ifc.inst_addr_o); end
        ifc.inst_ready_i = 1; cyc(); ifc.inst_ready_i = 0;
        n_cmp++; if (ifc.inst_valid_o !== 1'b0) begin n_bad++; $display("FAIL basic_pop: got %b want 0", ifc.inst_valid_o); end
    endtask

    task automatic test_backpressure();
        bit ok1, ok2;
        ifc.inst_ready_i = 0;
        do_fetch(32'h0, 32'hA000_0001, 0, ok1);
        do_fetch(32'h4, 32'hB000_0002, 0, ok2);
        n_cmp++; if (!(ok1 && ok2)) begin n_bad++; $display("FAIL bp_accept_timeout: got %b%b want 11", ok1, ok2); end
        ifc.pc_i = 32'h8; ifc.pc_valid_i = 1; #1;
        n_cmp++; if (ifc.pc_ready_o !== 1'b0) begin n_bad++; $display("FAIL bp_full_ready: got %b want 0", ifc.pc_ready_o); end
        n_cmp++; if (ifc.inst_addr_o !== 32'h0) begin n_bad++; $display("FAIL bp_head0_addr: got %h want 0", ifc.inst_addr_o); end
        n_cmp++; if (ifc.inst_o !== 32'hA000_0001) begin n_bad++; $display("FAIL bp_head0_data: got %h want a0000001", ifc.inst_o); end
        cyc();
        n_cmp++; if (ifc.imem_req_o !== 1'b0) begin n_bad++; $display("FAIL bp_no_req_when_full: got %b want 0", ifc.imem_req_o); end
        n_cmp++; if (ifc.pc_ready_o !== 1'b0) begin n_bad++; $display("FAIL bp_still_full: got %b want 0", ifc.pc_ready_o); end
        ifc.inst_ready_i = 1; cyc(); ifc.inst_ready_i = 0; #1;
        n_cmp++; if (ifc.pc_ready_o !== 1'b1) begin n_bad++; $display("FAIL bp_ready_after_pop: got %b want 1", ifc.pc_ready_o); end
        n_cmp++; if (ifc.inst_addr_o !== 32'h4) begin n_bad++; $display("FAIL bp_head1_addr: got %h want 4", ifc.inst_addr_o); end
        cyc(); ifc.pc_valid_i = 0;
        n_cmp++; if (ifc.imem_req_o !== 1'b1 || ifc.imem_addr_o !== 32'h8) begin n_bad++; $display("FAIL bp_req8: got %b/%h want 1/8", ifc.imem_req_o, ifc.imem_addr_o); end
        ifc.imem_gnt_i = 1; cyc(); ifc.imem_gnt_i = 0;
        ifc.imem_rvalid_i = 1; ifc.imem_rdata_i = 32'hC000_0003; cyc(); ifc.imem_rvalid_i = 0;
        ifc.inst_ready_i = 1;
        n_cmp++; if (ifc.inst_o !== 32'hB000_0002) begin n_bad++; $display("FAIL bp_pop_b: got %h want b0000002", ifc.inst_o); end
        cyc();
        n_cmp++; if (ifc.inst_addr_o !== 32'h8 || ifc.inst_o !== 32'hC000_0003) begin n_bad++; $display("FAIL bp_pop_c: got %h/%h want 8/c0000003", ifc.inst_addr_o, ifc.inst_o); end
        cyc(); ifc.inst_ready_i = 0;
        n_cmp++; if (ifc.inst_valid_o !== 1'b0) begin n_bad++; $display("FAIL bp_drained: got %b want 0", ifc.inst_valid_o); end
    endtask

    task automatic test_gnt_stall();
        ifc.pc_i = 32'h200; ifc.pc_valid_i = 1; cyc(); ifc.pc_valid_i = 0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (ifc.imem_req_o !== 1'b1 || ifc.imem_addr_o !== 32'h200) begin n_bad++; $display("FAIL stall_req_c%0d: got %b/%h want 1/200", i, ifc.imem_req_o, ifc.imem_addr_o); end
            cyc();
        end
        n_cmp++; if (ifc.imem_req_o !== 1'b1) begin n_bad++; $display("FAIL stall_req_final: got %b want 1", ifc.imem_req_o); end
        ifc.imem_gnt_i = 1; cyc(); ifc.imem_gnt_i = 0;
        n_cmp++; if (ifc.imem_req_o !== 1'b0) begin n_bad++; $display("FAIL stall_req_after_gnt: got %b want 0", ifc.imem_req_o); end
        ifc.imem_rvalid_i = 1; ifc.imem_rdata_i = 32'h1234_5678; cyc(); ifc.imem_rvalid_i = 0;
        n_cmp++; if (ifc.inst_valid_o !== 1'b1 || ifc.inst_o !== 32'h1234_5678) begin n_bad++; $display("FAIL stall_push: got %b/%h want 1/12345678", ifc.inst_valid_o, ifc.inst_o); end
        ifc.inst_ready_i = 1; cyc(); ifc.inst_ready_i = 0;
        n_cmp++; if (ifc.inst_valid_o !== 1'b0) begin n_bad++; $display("FAIL stall_single_push: got %b want 0", ifc.inst_valid_o); end
    endtask

    task automatic test_flush_wait();
        ifc.pc_i = 32'h300; ifc.pc_valid_i = 1; cyc(); ifc.pc_valid_i = 0;
        ifc.imem_gnt_i = 1; cyc(); ifc.imem_gnt_i = 0;
        ifc.flush_i = 1; #1;
        n_cmp++; if (ifc.pc_ready_o !== 1'b0) begin n_bad++; $display("FAIL flush_ready_c0: got %b want 0", ifc.pc_ready_o); end
        cyc(); ifc.flush_i = 0;
        ifc.pc_i = 32'h400; ifc.pc_valid_i = 1; #1;
        n_cmp++; if (ifc.pc_ready_o !== 1'b0) begin n_bad++; $display("FAIL flush_ready_c1: got %b want 0", ifc.pc_ready_o); end
        cyc(); #1;
        n_cmp++; if (ifc.pc_ready_o !== 1'b0) begin n_bad++; $display("FAIL flush_ready_c2: got %b want 0", ifc.pc_ready_o); end
        cyc();
        ifc.imem_rvalid_i = 1; ifc.imem_rdata_i = 32'hDEAD_BEEF; #1;
        n_cmp++; if (ifc.pc_ready_o !== 1'b0) begin n_bad++; $display("FAIL flush_ready_rv: got %b want 0", ifc.pc_ready_o); end
        cyc(); ifc.imem_rvalid_i = 0; ifc.pc_valid_i = 0;
        n_cmp++; if (ifc.inst_valid_o !== 1'b0) begin n_bad++; $display("FAIL flush_no_push: got %b want 0", ifc.inst_valid_o); end
        n_cmp++; if (ifc.imem_req_o !== 1'b0) begin n_bad++; $display("FAIL flush_no_req: got %b want 0", ifc.imem_req_o); end
        #1;
        n_cmp++; if (ifc.pc_ready_o !== 1'b1) begin n_bad++; $display("FAIL flush_ready_after: got %b want 1", ifc.pc_ready_o); end
        cyc();
    endtask

    task automatic test_misaligned();
        ifc.pc_i = 32'h0000_0106; ifc.pc_valid_i = 1; cyc(); ifc.pc_valid_i = 0;
        n_cmp++; if (ifc.imem_addr_o !== 32'h0000_0104) begin n_bad++; $display("FAIL mis_imem_addr: got %h want 00000104", ifc.imem_addr_o); end
        ifc.imem_gnt_i = 1; cyc(); ifc.imem_gnt_i = 0;
        ifc.imem_rvalid_i = 1; ifc.imem_rdata_i = 32'h0000_0093; cyc(); ifc.imem_rvalid_i = 0;
        n_cmp++; if (ifc.inst_addr_o !== 32'h0000_0104) begin n_bad++; $display("FAIL mis_inst_addr: got %h want 00000104", ifc.inst_addr_o); end
        ifc.inst_ready_i = 1; cyc(); ifc.inst_ready_i = 0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_fetch(32'h10, 32'h5555_0010, 1, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rmid_accept_timeout: got 0 want 1"); end
        ifc.pc_i = 32'h14; ifc.pc_valid_i = 1; cyc(); ifc.pc_valid_i = 0;
        ifc.imem_gnt_i = 1; cyc(); ifc.imem_gnt_i = 0;
        n_cmp++; if (ifc.inst_valid_o !== 1'b1) begin n_bad++; $display("FAIL rmid_one_entry: got %b want 1", ifc.inst_valid_o); end
        rst = 1; cyc(); rst = 0;
        n_cmp++; if (ifc.inst_valid_o !== 1'b0 || ifc.inst_o !== 32'h0 || ifc.inst_addr_o !== 32'h0) begin n_bad++; $display("FAIL rmid_cleared: got %b/%h/%h want 0/0/0", ifc.inst_valid_o, ifc.inst_o, ifc.inst_addr_o); end
        ifc.imem_rvalid_i = 1; ifc.imem_rdata_i = 32'hBAD0_0014; cyc(); ifc.imem_rvalid_i = 0;
        n_cmp++; if (ifc.inst_valid_o !== 1'b0) begin n_bad++; $display("FAIL rmid_stale_push: got %b want 0", ifc.inst_valid_o); end
        n_cmp++; if (ifc.imem_req_o !== 1'b0) begin n_bad++; $display("FAIL rmid_req: got %b want 0", ifc.imem_req_o); end
        #1;
        n_cmp++; if (ifc.pc_ready_o !== 1'b1) begin n_bad++; $display("FAIL rmid_ready: got %b want 1", ifc.pc_ready_o); end
        cyc();
    endtask

    // Transaction-level model: a fetch is either absent, asking memory, pending a
    // response that will be kept, or orphaned by a flush with its response still due.
    localparam int T_NONE = 0, T_ASKING = 1, T_PENDING = 2, T_ORPHAN = 3;

    task automatic test_random();
        int          txn = T_NONE;
        int          wcnt = 0;
        logic [31:0] req_addr = '0;
        logic [63:0] q[$];
        bit          exp_ready, g, r, pop, acc;
        for (int c = 0; c < 3000; c++) begin
            ifc.pc_valid_i   = ($urandom % 2) == 0;
            ifc.pc_i         = $urandom;
            ifc.inst_ready_i = ($urandom % 3) != 0;
            ifc.flush_i      = ($urandom % 20) == 0;
            ifc.imem_gnt_i   = ($urandom % 2) == 0;
            if (txn == T_PENDING || txn == T_ORPHAN) ifc.imem_rvalid_i = (wcnt == 0);
            else ifc.imem_rvalid_i = ($urandom % 8) == 0;
            ifc.imem_rdata_i = $urandom;
            #1;
            exp_ready = (txn == T_NONE) && (q.size() < DEPTH) && !ifc.flush_i;
            n_cmp++; if (ifc.pc_ready_o !== exp_ready) begin n_bad++; $display("FAIL rnd_pc_ready c%0d: got %b want %b", c, ifc.pc_ready_o, exp_ready); end
            n_cmp++; if (ifc.imem_req_o !== (txn == T_ASKING)) begin n_bad++; $display("FAIL rnd_req c%0d: got %b want %b", c, ifc.imem_req_o, txn == T_ASKING); end
            if (txn == T_ASKING) begin
                n_cmp++; if (ifc.imem_addr_o !== req_addr) begin n_bad++; $display("FAIL rnd_req_addr c%0d: got %h want %h", c, ifc.imem_addr_o, req_addr); end
            end
            n_cmp++; if (ifc.inst_valid_o !== (q.size() != 0)) begin n_bad++; $display("FAIL rnd_valid c%0d: got %b want %b", c, ifc.inst_valid_o, q.size() != 0); end
            if (q.size() != 0) begin
                n_cmp++; if ({ifc.inst_addr_o, ifc.inst_o} !== q[0]) begin n_bad++; $display("FAIL rnd_head c%0d: got %h_%h want %h", c, ifc.inst_addr_o, ifc.inst_o, q[0]); end
            end
            acc = ifc.pc_valid_i && exp_ready;
            g   = (txn == T_ASKING) && ifc.imem_gnt_i;
            r   = ifc.imem_rvalid_i;
            pop = (q.size() != 0) && ifc.inst_ready_i;
            if ((txn == T_PENDING || txn == T_ORPHAN) && !r) wcnt--;
            if (g) wcnt = $urandom_range(0, 3);
            if (ifc.flush_i) begin
                q.delete();
                if (txn == T_ASKING) txn = g ? T_ORPHAN : T_NONE;
                else if (txn == T_PENDING || txn == T_ORPHAN) txn = r ? T_NONE : T_ORPHAN;
            end else begin
                if (pop) void'(q.pop_front());
                case (txn)
                    T_NONE:    if (acc) begin txn = T_ASKING; req_addr = {ifc.pc_i[31:2], 2'b00}; end
                    T_ASKING:  if (g) txn = T_PENDING;
                    T_PENDING: if (r) begin q.push_back({req_addr, ifc.imem_rdata_i}); txn = T_NONE; end
                    default:   if (r) txn = T_NONE;
                endcase
            end
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_basic();
        test_backpressure();
        test_gnt_stall();
        test_flush_wait();
        test_misaligned();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
